// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// loader state encoding and frame field widths.
package loader_pkg;

    localparam int LEN_WIDTH      = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } load_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects bytes into little-endian 32-bit words. The first three bytes
// are buffered; the fourth byte is combined combinationally so the parent
// can register the finished word on the same edge that accepts that byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_byte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [23:0] low_bytes;

    assign word       = {data_byte, low_bytes};
    assign word_valid = strobe && !clear && (byte_idx == 2'(BYTES_PER_WORD - 1));

    // Track position within the word and hold the lower three bytes; clear wins over strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (strobe) begin
            case (byte_idx)
                2'd0:    low_bytes[7:0]   <= data_byte;
                2'd1:    low_bytes[15:8]  <= data_byte;
                2'd2:    low_bytes[23:16] <= data_byte;
                default: low_bytes        <= 24'd0;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Parses a length-prefixed byte
// stream, writes little-endian words to the instruction memory starting at
// BASE_ADDR and holds the core in reset until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over the data bytes.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err
);

    // Number of words that fit between BASE_ADDR and the top of memory
    localparam logic [31:0] CAPACITY = 32'((1 << ADDR_WIDTH) - BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);

    load_state_t           state;
    logic [7:0]            len_lo;
    logic [LEN_WIDTH-1:0]  last_word;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  accept;
    logic [31:0]           req_words;
    logic [31:0]           word;
    logic                  word_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign accept    = in_valid && in_ready;
    assign req_words = {16'd0, in_data, len_lo};

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .data_byte  (in_data),
        .strobe     (accept && (state == DATA)),
        .clear      (state != DATA),
        .word       (word),
        .word_valid (word_valid)
    );

    // Frame FSM with registered handshake, memory write and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LEN0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            len_lo     <= 8'd0;
            last_word  <= '0;
            word_cnt   <= '0;
            wr_addr    <= FIRST_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (load_done) begin
                core_rst <= 1'b0;
            end
            case (state)
                LEN0: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        word_cnt <= '0;
                        wr_addr  <= FIRST_ADDR;
                        if (req_words > CAPACITY) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else if (req_words == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state     <= CSUM;
`else
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else begin
                            state     <= DATA;
                            last_word <= {in_data, len_lo} - 16'd1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (word_valid) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wr_addr;
                            imem_wdata <= word;
                            wr_addr    <= wr_addr + ADDR_WIDTH'(1);
                            word_cnt   <= word_cnt + 16'd1;
                            if (word_cnt == last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state     <= CSUM;
`else
                                state     <= DONE;
                                in_ready  <= 1'b0;
                                load_done <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader. The driver builds frames from
// word lists, pushes the expected memory writes when the completing byte is
// accepted, and a monitor pops and compares every write strobe it observes.
module tb_imem_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int BASE_ADDR  = 0;
    localparam int CAPACITY   = (1 << ADDR_WIDTH) - BASE_ADDR;
    localparam int HALF       = 5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        int          addr;
        logic [31:0] data;
        longint      due;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            in_data = 8'd0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_rst;
    logic                  load_done;
    logic                  load_err;

    int checks = 0;
    int errors = 0;

    wr_t         sb[$];
    logic [7:0]  frame_q[$];
    logic [31:0] word_q[$];
    int          n_accept;

    imem_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #HALF clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference frame: length, little-endian words, optional XOR checksum of data bytes
    task automatic buildFrame(input int n, input bit bad_csum);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'd0;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        foreach (word_q[k]) begin
            w = word_q[k];
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        if (CSUM_ON) frame_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
        n_accept = (n > CAPACITY) ? 2 : frame_q.size();
    endtask

    task automatic randomWords(input int n);
        word_q.delete();
        for (int k = 0; k < n; k++) word_q.push_back($urandom);
    endtask

    // gaps: 0 = back-to-back, 1 = valid toggles every cycle, 2 = random idle cycles
    task automatic applyStimulus(input int gaps);
        wr_t e;
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            if (gaps == 1 && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end else if (gaps == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_data  = frame_q[i];
            in_valid = 1'b1;
            checkOutput("in_ready", 32'(in_ready), 32'(i < n_accept));
            @(posedge clk);
            if (i < n_accept && i >= 2 && i < 2 + 4 * word_q.size() && ((i - 2) % 4) == 3) begin
                e.addr = BASE_ADDR + (i - 2) / 4;
                e.data = word_q[(i - 2) / 4];
                e.due  = longint'($time);
                sb.push_back(e);
            end
        end
    endtask

    task automatic finishFrame(input bit exp_done, input bit exp_err);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("load_done", 32'(load_done), 32'(exp_done));
        checkOutput("load_err", 32'(load_err), 32'(exp_err));
        checkOutput("core_rst_hold", 32'(core_rst), 32'd1);
        checkOutput("in_ready_end", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("core_rst_after", 32'(core_rst), 32'(!exp_done));
        repeat (3) @(negedge clk);
        checkOutput("pending_writes", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic applyReset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected write, one cycle after acceptance
    always @(negedge clk) begin
        wr_t e;
        if (!rst && imem_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: actual imem_we=1 addr=0x%0h data=0x%0h required no write", imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                checkOutput("imem_addr", 32'(imem_addr), 32'(e.addr));
                checkOutput("imem_wdata", imem_wdata, e.data);
                checkOutput("write_latency", 32'(longint'($time) - e.due), 32'(HALF));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
        checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
        checkOutput("reset_core_rst", 32'(core_rst), 32'd1);
        checkOutput("reset_load_done", 32'(load_done), 32'd0);
        checkOutput("reset_load_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] two-word reference frame");
        word_q = '{32'h0000_0013, 32'h0010_0093};
        buildFrame(2, 1'b0);
        applyStimulus(0);
        finishFrame(1'b1, 1'b0);
        frame_q = '{8'h00, 8'h11, 8'h22};
        n_accept = 0;
        applyStimulus(0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("done_sticky", 32'(load_done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] bad checksum");
        applyReset();
        word_q = '{32'h0000_0013, 32'h0010_0093};
        buildFrame(2, 1'b1);
        applyStimulus(0);
        finishFrame(1'b0, 1'b1);
`endif

        $display("[TB] oversize length");
        applyReset();
        word_q.delete();
        buildFrame(CAPACITY + 1, 1'b0);
        applyStimulus(0);
        finishFrame(1'b0, 1'b1);
        frame_q = '{8'h13, 8'h00, 8'h00, 8'h00};
        n_accept = 0;
        applyStimulus(0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("err_sticky", 32'(load_err), 32'd1);

        $display("[TB] random oversize length");
        applyReset();
        buildFrame($urandom_range(CAPACITY + 1, 65535), 1'b0);
        applyStimulus(2);
        finishFrame(1'b0, 1'b1);

        $display("[TB] single word with toggling valid");
        applyReset();
        randomWords(1);
        buildFrame(1, 1'b0);
        applyStimulus(1);
        finishFrame(1'b1, 1'b0);

        $display("[TB] reset in the middle of a load");
        applyReset();
        randomWords(2);
        buildFrame(2, 1'b0);
        frame_q = frame_q[0:7];
        n_accept = 8;
        applyStimulus(0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("partial_pending", 32'(sb.size()), 32'd0);
        applyReset();
        word_q = '{32'hDEAD_BEEF};
        buildFrame(1, 1'b0);
        applyStimulus(0);
        finishFrame(1'b1, 1'b0);

        $display("[TB] empty image");
        applyReset();
        word_q.delete();
        buildFrame(0, 1'b0);
        applyStimulus(0);
        finishFrame(1'b1, 1'b0);

        $display("[TB] random frames");
        for (int f = 0; f < 5; f++) begin
            applyReset();
            randomWords($urandom_range(1, 7));
            buildFrame(word_q.size(), 1'b0);
            applyStimulus(2);
            finishFrame(1'b1, 1'b0);
        end

        $display("[TB] image filling the whole memory");
        applyReset();
        randomWords(CAPACITY);
        buildFrame(CAPACITY, 1'b0);
        applyStimulus(0);
        finishFrame(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
